// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: sequencing controller for the multi-cycle MIPS-subset
// datapath. It walks fetch/decode/execute/memory/write-back states and issues
// the per-state control strobes for the PC/IR/register-file/ALU/memory path.
// It also implements a memory wait-state handshake, a halt request held in
// FETCH, sticky illegal-opcode detection and a retired-instruction counter.
//
// Ports:
//   clock, rst        clock (rising edge) and async active-high reset
//   opcode[5:0]       IR[31:26], valid from DECODE onward
//   mem_ready         memory completes the current read/write this cycle
//   halt              hold in FETCH without issuing a fetch
//   pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
//   reg_dst, RegWr, mem_to_reg, alu_src_a, alu_src_b[1:0],
//   alu_opcode[1:0], pc_source[1:0]
//                     datapath controls, combinational from state
//                     (plus mem_ready/halt); all 0 while rst=1
//   state[3:0]        current state (debug), registered
//   illegal_op        sticky unknown-opcode flag, registered
//   retired[31:0]     retired-instruction count, registered, wraps
module multicycle_ctrl_fsm (
    input  logic        clock,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    input  logic        halt,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_dst,
    output logic        RegWr,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_opcode,
    output logic [1:0]  pc_source,
    output logic [3:0]  state,
    output logic        illegal_op,
    output logic [31:0] retired
);

    localparam int unsigned STATE_W = 4;
    localparam int unsigned CNT_W   = 32;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_RD    = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WR    = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    state_t state_q;
    state_t state_nxt;
    logic   retire;
    logic   illegal_set;

    // State, sticky illegal flag and retire counter.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q    <= S_FETCH;
            illegal_op <= 1'b0;
            retired    <= '0;
        end else begin
            state_q <= state_nxt;
            if (illegal_set) begin
                illegal_op <= 1'b1;
            end
            if (retire) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

    assign state = state_q;

    // Next-state and control decode; everything stays 0 while in reset.
    always_comb begin
        state_nxt     = state_q;
        retire        = 1'b0;
        illegal_set   = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        RegWr         = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_opcode    = 2'b00;
        pc_source     = 2'b00;

        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    // Halt parks here with no request outstanding.
                    if (!halt) begin
                        mem_read  = 1'b1;
                        alu_src_b = 2'b01;
                        if (mem_ready) begin
                            ir_write  = 1'b1;
                            pc_write  = 1'b1;
                            state_nxt = S_DECODE;
                        end
                    end
                end
                S_DECODE: begin
                    // Precompute branch target while the opcode is decoded.
                    alu_src_b = 2'b11;
                    case (opcode)
                        OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
                        OP_R:         state_nxt = S_R_EXEC;
                        OP_BEQ:       state_nxt = S_BRANCH;
                        OP_J:         state_nxt = S_JUMP;
                        OP_ADDI:      state_nxt = S_ADDI_EXEC;
                        default: begin
                            state_nxt   = S_FETCH;
                            illegal_set = 1'b1;
                        end
                    endcase
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_nxt = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                    if (mem_ready) begin
                        state_nxt = S_MEM_WB;
                    end
                end
                S_MEM_WB: begin
                    RegWr      = 1'b1;
                    mem_to_reg = 1'b1;
                    state_nxt  = S_FETCH;
                    retire     = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    if (mem_ready) begin
                        state_nxt = S_FETCH;
                        retire    = 1'b1;
                    end
                end
                S_R_EXEC: begin
                    alu_src_a  = 1'b1;
                    alu_opcode = 2'b10;
                    state_nxt  = S_R_WB;
                end
                S_R_WB: begin
                    RegWr     = 1'b1;
                    reg_dst   = 1'b1;
                    state_nxt = S_FETCH;
                    retire    = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_opcode    = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                    state_nxt     = S_FETCH;
                    retire        = 1'b1;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                    state_nxt = S_FETCH;
                    retire    = 1'b1;
                end
                S_ADDI_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_nxt = S_ADDI_WB;
                end
                S_ADDI_WB: begin
                    RegWr     = 1'b1;
                    state_nxt = S_FETCH;
                    retire    = 1'b1;
                end
                // Unused codes 12-15 fall back to FETCH.
                default: state_nxt = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm. Each scenario task drives a
// per-cycle table of inputs, pushes the hand-derived expected observation to
// a scoreboard queue, and pops/compares it against the DUT just after the
// inputs settle (inputs change on the falling edge).
module tb_multicycle_ctrl_fsm;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    // ctrl bit order: pc_write pc_write_cond iord mem_read mem_write ir_write
    // reg_dst RegWr mem_to_reg alu_src_a alu_src_b[1:0] alu_opcode[1:0] pc_source[1:0]
    localparam logic [15:0] C_NONE    = 16'h0000;
    localparam logic [15:0] C_FETCH_W = 16'h1010;
    localparam logic [15:0] C_FETCH_R = 16'h9410;
    localparam logic [15:0] C_DECODE  = 16'h0030;
    localparam logic [15:0] C_MADDR   = 16'h0060;
    localparam logic [15:0] C_MEMRD   = 16'h3000;
    localparam logic [15:0] C_MEMWB   = 16'h0180;
    localparam logic [15:0] C_MEMWR   = 16'h2800;
    localparam logic [15:0] C_REXEC   = 16'h0048;
    localparam logic [15:0] C_RWB     = 16'h0300;
    localparam logic [15:0] C_BRANCH  = 16'h4045;
    localparam logic [15:0] C_JUMP    = 16'h8002;
    localparam logic [15:0] C_AEXEC   = 16'h0060;
    localparam logic [15:0] C_AWB     = 16'h0100;

    localparam logic [3:0] F = 4'd0;

    typedef struct packed {
        logic [5:0]  op;
        logic        rdy;
        logic        hlt;
        logic [52:0] exp;
    } rec_t;

    logic        clock;
    logic        rst;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        halt;
    logic        pc_write;
    logic        pc_write_cond;
    logic        iord;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        reg_dst;
    logic        RegWr;
    logic        mem_to_reg;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_opcode;
    logic [1:0]  pc_source;
    logic [3:0]  state;
    logic        illegal_op;
    logic [31:0] retired;

    logic [15:0] ctrl;
    logic [52:0] obs;
    logic [52:0] sb[$];
    int          checks;
    int          errors;

    multicycle_ctrl_fsm dut (
        .clock         (clock),
        .rst           (rst),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .halt          (halt),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .RegWr         (RegWr),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_opcode    (alu_opcode),
        .pc_source     (pc_source),
        .state         (state),
        .illegal_op    (illegal_op),
        .retired       (retired)
    );

    assign ctrl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                   reg_dst, RegWr, mem_to_reg, alu_src_a, alu_src_b, alu_opcode,
                   pc_source};
    assign obs  = {state, ctrl, illegal_op, retired};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic rec_t mk(input logic [5:0] op, input logic rdy, input logic hlt,
                                input logic [3:0] st, input logic [15:0] c,
                                input logic ill, input logic [31:0] ret);
        rec_t r;
        r.op  = op;
        r.rdy = rdy;
        r.hlt = hlt;
        r.exp = {st, c, ill, ret};
        return r;
    endfunction

    task automatic test_reset();
        logic [52:0] e;
        mem_ready = 1'b1;
        sb.push_back({4'd0, C_NONE, 1'b0, 32'd0});
        #1;
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_init got %h want %h", obs, e);
        end
        @(negedge clock);
        rst = 1'b0;
    endtask

    task automatic test_lw();
        rec_t        seq[$];
        logic [52:0] e;
        seq.push_back(mk(OP_LW, 1'b1, 1'b0, F,     C_FETCH_R, 1'b0, 32'd0));
        seq.push_back(mk(OP_LW, 1'b1, 1'b0, 4'd1,  C_DECODE,  1'b0, 32'd0));
        seq.push_back(mk(OP_LW, 1'b1, 1'b0, 4'd2,  C_MADDR,   1'b0, 32'd0));
        seq.push_back(mk(OP_LW, 1'b1, 1'b0, 4'd3,  C_MEMRD,   1'b0, 32'd0));
        seq.push_back(mk(OP_LW, 1'b1, 1'b0, 4'd4,  C_MEMWB,   1'b0, 32'd0));
        seq.push_back(mk(OP_LW, 1'b0, 1'b0, F,     C_FETCH_W, 1'b0, 32'd1));
        foreach (seq[i]) begin
            opcode = seq[i].op; mem_ready = seq[i].rdy; halt = seq[i].hlt;
            sb.push_back(seq[i].exp);
            #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL lw[%0d] got %h want %h", i, obs, e);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_wait_states();
        rec_t        seq[$];
        logic [52:0] e;
        seq.push_back(mk(OP_R, 1'b0, 1'b0, F,    C_FETCH_W, 1'b0, 32'd1));
        seq.push_back(mk(OP_R, 1'b0, 1'b0, F,    C_FETCH_W, 1'b0, 32'd1));
        seq.push_back(mk(OP_R, 1'b0, 1'b0, F,    C_FETCH_W, 1'b0, 32'd1));
        seq.push_back(mk(OP_R, 1'b1, 1'b0, F,    C_FETCH_R, 1'b0, 32'd1));
        seq.push_back(mk(OP_R, 1'b0, 1'b0, 4'd1, C_DECODE,  1'b0, 32'd1));
        seq.push_back(mk(OP_R, 1'b1, 1'b0, 4'd6, C_REXEC,   1'b0, 32'd1));
        seq.push_back(mk(OP_R, 1'b1, 1'b0, 4'd7, C_RWB,     1'b0, 32'd1));
        seq.push_back(mk(OP_R, 1'b0, 1'b0, F,    C_FETCH_W, 1'b0, 32'd2));
        foreach (seq[i]) begin
            opcode = seq[i].op; mem_ready = seq[i].rdy; halt = seq[i].hlt;
            sb.push_back(seq[i].exp);
            #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL wait[%0d] got %h want %h", i, obs, e);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_sw_addi();
        rec_t        seq[$];
        logic [52:0] e;
        seq.push_back(mk(OP_SW,   1'b1, 1'b0, F,     C_FETCH_R, 1'b0, 32'd2));
        seq.push_back(mk(OP_SW,   1'b1, 1'b0, 4'd1,  C_DECODE,  1'b0, 32'd2));
        seq.push_back(mk(OP_SW,   1'b1, 1'b0, 4'd2,  C_MADDR,   1'b0, 32'd2));
        seq.push_back(mk(OP_SW,   1'b0, 1'b0, 4'd5,  C_MEMWR,   1'b0, 32'd2));
        seq.push_back(mk(OP_SW,   1'b0, 1'b0, 4'd5,  C_MEMWR,   1'b0, 32'd2));
        seq.push_back(mk(OP_SW,   1'b1, 1'b0, 4'd5,  C_MEMWR,   1'b0, 32'd2));
        seq.push_back(mk(OP_ADDI, 1'b1, 1'b0, F,     C_FETCH_R, 1'b0, 32'd3));
        seq.push_back(mk(OP_ADDI, 1'b1, 1'b0, 4'd1,  C_DECODE,  1'b0, 32'd3));
        seq.push_back(mk(OP_ADDI, 1'b1, 1'b0, 4'd10, C_AEXEC,   1'b0, 32'd3));
        seq.push_back(mk(OP_ADDI, 1'b1, 1'b0, 4'd11, C_AWB,     1'b0, 32'd3));
        seq.push_back(mk(OP_ADDI, 1'b0, 1'b0, F,     C_FETCH_W, 1'b0, 32'd4));
        foreach (seq[i]) begin
            opcode = seq[i].op; mem_ready = seq[i].rdy; halt = seq[i].hlt;
            sb.push_back(seq[i].exp);
            #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL sw_addi[%0d] got %h want %h", i, obs, e);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_branch_jump();
        rec_t        seq[$];
        logic [52:0] e;
        seq.push_back(mk(OP_BEQ, 1'b1, 1'b0, F,    C_FETCH_R, 1'b0, 32'd4));
        seq.push_back(mk(OP_BEQ, 1'b1, 1'b0, 4'd1, C_DECODE,  1'b0, 32'd4));
        seq.push_back(mk(OP_BEQ, 1'b1, 1'b0, 4'd8, C_BRANCH,  1'b0, 32'd4));
        seq.push_back(mk(OP_J,   1'b1, 1'b0, F,    C_FETCH_R, 1'b0, 32'd5));
        seq.push_back(mk(OP_J,   1'b1, 1'b0, 4'd1, C_DECODE,  1'b0, 32'd5));
        seq.push_back(mk(OP_J,   1'b1, 1'b0, 4'd9, C_JUMP,    1'b0, 32'd5));
        seq.push_back(mk(OP_J,   1'b0, 1'b0, F,    C_FETCH_W, 1'b0, 32'd6));
        foreach (seq[i]) begin
            opcode = seq[i].op; mem_ready = seq[i].rdy; halt = seq[i].hlt;
            sb.push_back(seq[i].exp);
            #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL br_j[%0d] got %h want %h", i, obs, e);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_illegal();
        rec_t        seq[$];
        logic [52:0] e;
        seq.push_back(mk(OP_BAD, 1'b1, 1'b0, F,    C_FETCH_R, 1'b0, 32'd6));
        seq.push_back(mk(OP_BAD, 1'b1, 1'b0, 4'd1, C_DECODE,  1'b0, 32'd6));
        seq.push_back(mk(OP_R,   1'b1, 1'b0, F,    C_FETCH_R, 1'b1, 32'd6));
        seq.push_back(mk(OP_R,   1'b1, 1'b0, 4'd1, C_DECODE,  1'b1, 32'd6));
        seq.push_back(mk(OP_R,   1'b1, 1'b0, 4'd6, C_REXEC,   1'b1, 32'd6));
        seq.push_back(mk(OP_R,   1'b1, 1'b0, 4'd7, C_RWB,     1'b1, 32'd6));
        seq.push_back(mk(OP_R,   1'b0, 1'b0, F,    C_FETCH_W, 1'b1, 32'd7));
        foreach (seq[i]) begin
            opcode = seq[i].op; mem_ready = seq[i].rdy; halt = seq[i].hlt;
            sb.push_back(seq[i].exp);
            #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL illegal[%0d] got %h want %h", i, obs, e);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset_mid();
        rec_t        seq[$];
        rec_t        post[$];
        logic [52:0] e;
        seq.push_back(mk(OP_LW, 1'b1, 1'b0, F,    C_FETCH_R, 1'b1, 32'd7));
        seq.push_back(mk(OP_LW, 1'b1, 1'b0, 4'd1, C_DECODE,  1'b1, 32'd7));
        seq.push_back(mk(OP_LW, 1'b1, 1'b0, 4'd2, C_MADDR,   1'b1, 32'd7));
        seq.push_back(mk(OP_LW, 1'b0, 1'b0, 4'd3, C_MEMRD,   1'b1, 32'd7));
        seq.push_back(mk(OP_LW, 1'b0, 1'b0, 4'd3, C_MEMRD,   1'b1, 32'd7));
        foreach (seq[i]) begin
            opcode = seq[i].op; mem_ready = seq[i].rdy; halt = seq[i].hlt;
            sb.push_back(seq[i].exp);
            #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL rst_mid[%0d] got %h want %h", i, obs, e);
            end
            @(negedge clock);
        end
        // Still in MEM_RD; reset lands between clock edges.
        #2;
        rst       = 1'b1;
        mem_ready = 1'b1;
        sb.push_back({4'd0, C_NONE, 1'b0, 32'd0});
        #1;
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL rst_async got %h want %h", obs, e);
        end
        @(negedge clock);
        rst = 1'b0;
        post.push_back(mk(OP_LW, 1'b0, 1'b0, F, C_FETCH_W, 1'b0, 32'd0));
        foreach (post[i]) begin
            opcode = post[i].op; mem_ready = post[i].rdy; halt = post[i].hlt;
            sb.push_back(post[i].exp);
            #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL rst_release[%0d] got %h want %h", i, obs, e);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_halt_wrap();
        rec_t        seq[$];
        rec_t        wrap[$];
        logic [52:0] e;
        for (int k = 0; k < 5; k++) begin
            seq.push_back(mk(OP_J, 1'b1, 1'b1, F, C_NONE, 1'b0, 32'd0));
        end
        foreach (seq[i]) begin
            opcode = seq[i].op; mem_ready = seq[i].rdy; halt = seq[i].hlt;
            sb.push_back(seq[i].exp);
            #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL halt[%0d] got %h want %h", i, obs, e);
            end
            @(negedge clock);
        end
        // Counter preload while parked in FETCH under halt.
        force dut.retired = 32'hFFFF_FFFF;
        #1;
        release dut.retired;
        wrap.push_back(mk(OP_J, 1'b1, 1'b0, F,    C_FETCH_R, 1'b0, 32'hFFFF_FFFF));
        wrap.push_back(mk(OP_J, 1'b1, 1'b0, 4'd1, C_DECODE,  1'b0, 32'hFFFF_FFFF));
        wrap.push_back(mk(OP_J, 1'b1, 1'b0, 4'd9, C_JUMP,    1'b0, 32'hFFFF_FFFF));
        wrap.push_back(mk(OP_J, 1'b0, 1'b0, F,    C_FETCH_W, 1'b0, 32'd0));
        foreach (wrap[i]) begin
            opcode = wrap[i].op; mem_ready = wrap[i].rdy; halt = wrap[i].hlt;
            sb.push_back(wrap[i].exp);
            #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL wrap[%0d] got %h want %h", i, obs, e);
            end
            @(negedge clock);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        opcode    = 6'd0;
        mem_ready = 1'b0;
        halt      = 1'b0;
        repeat (2) @(negedge clock);
        test_reset();
        test_lw();
        test_wait_states();
        test_sw_addi();
        test_branch_jump();
        test_illegal();
        test_reset_mid();
        test_halt_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
